// File: rtl/uart_rx_byte.sv
// uart_rx_byte: cycle-counting 8N1 serial receiver feeding a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err_o.
module uart_rx_byte #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          overrun_q;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q;
    logic          parity_err_q;
`endif

    logic rxs;
    logic fall;

    assign rxs  = rx_sync_q;
    assign fall = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx_i;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // A commit later in this block overrides the accept, so a
            // simultaneous accept+commit leaves valid set with the new byte.
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        cnt_q   <= '0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs;
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        par_bad_q <= ^{shift_q, rxs};
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        if (!rxs) begin
                            frame_err_q <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (par_bad_q) begin
                            parity_err_q <= 1'b1;
                        end
`endif
                        else begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            if (valid_q && !ready_i) begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at CLK_HZ=16, BAUD=1: directed scenarios plus random frames,
// checked against a frame-level model of the holding register and error pulses.
`timescale 1ns/1ps
module tb_uart_rx_byte;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // Commit edge counted from the first edge that samples the start bit low.
    localparam int LAT  = 2 + 1 + CPB / 2 + 9 * CPB + (PAR ? CPB : 0);
    localparam int K_OK = 0;
    localparam int K_FE = 1;
    localparam int K_PE = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;

    uart_rx_byte #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Frame-level model: a holding register updated when a frame's stop sample is due.
    ev_t        ev_q[$];
    ev_t        m_ev;
    bit         chk_en = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    int         last_ev;
    int         exp_fe, exp_ov, exp_pe;
    int         acc_fe, acc_ov, acc_pe;

    task automatic model_clear();
        m_valid = 1'b0;
        m_data  = 8'h00;
        ev_q.delete();
        last_ev = -100;
        exp_fe = 0; exp_ov = 0; exp_pe = 0;
        acc_fe = 0; acc_ov = 0; acc_pe = 0;
    endtask

    always @(posedge clk) begin
        if (chk_en) begin
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc + 1) begin
                m_ev    = ev_q.pop_front();
                last_ev = cyc + 1;
                exp_fe  = (m_ev.kind == K_FE) ? 1 : 0;
                exp_pe  = (m_ev.kind == K_PE) ? 1 : 0;
                exp_ov  = 0;
                if (m_ev.kind == K_OK) begin
                    if (m_valid && !ready_i) exp_ov = 1;
                    m_valid = 1'b1;
                    m_data  = m_ev.data;
                end else if (m_valid && ready_i) begin
                    m_valid = 1'b0;
                end
            end else if (m_valid && ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare; cycles within the +-1 latency tolerance of a frame
    // end only accumulate pulses, which are then checked as a window total.
    always @(negedge clk) begin
        if (chk_en) begin
            bit near;
            near = (ev_q.size() > 0 && ev_q[0].cyc - cyc <= 2) || (cyc - last_ev <= 1);
            if (near) begin
                acc_fe += int'(frame_err_o);
                acc_ov += int'(overrun_o);
                acc_pe += int'(parity_err_o);
            end else begin
                check("cyc_valid", valid_o, m_valid);
                check("cyc_data", data_o, m_data);
                check("cyc_frame_err", frame_err_o, 0);
                check("cyc_overrun", overrun_o, 0);
                check("cyc_parity_err", parity_err_o, 0);
            end
            if (cyc == last_ev + 2) begin
                check("win_frame_err", acc_fe, exp_fe);
                check("win_overrun", acc_ov, exp_ov);
                check("win_parity_err", acc_pe, exp_pe);
                acc_fe = 0; acc_ov = 0; acc_pe = 0;
            end
        end
    end

    // Pulse counters (high cycles) and valid rise time for the directed checks.
    int   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int   rise_cyc = -1;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        fe_cnt += int'(frame_err_o);
        ov_cnt += int'(overrun_o);
        pe_cnt += int'(parity_err_o);
        if (valid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = valid_o;
    end

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                              output int s);
        ev_t ev;
        s       = cyc;
        ev.cyc  = s + LAT;
        ev.data = d;
        ev.kind = bad_stop ? K_FE : (bad_par ? K_PE : K_OK);
        ev_q.push_back(ev);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit((^d) ^ bad_par);
        drive_bit(!bad_stop);
    endtask

    task automatic accept();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int s;
        int fe0, ov0, pe0;
        logic [7:0] d;
        bit bs, bp;

        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_flags", {frame_err_o, overrun_o, parity_err_o}, 0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;

        // 0xA5 held with ready low, then a single-cycle accept
        send_frame(8'hA5, 1'b0, 1'b0, s);
        check_range("a5_latency", rise_cyc - s, LAT - 1, LAT + 1);
        check("a5_data", data_o, 8'hA5);
        repeat (30) @(negedge clk);
        check("a5_hold_valid", valid_o, 1);
        accept();
        check("a5_valid_fall", valid_o, 0);
        check("a5_data_kept", data_o, 8'hA5);

        // 0x3C with a low stop bit, then 0x55
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, s);
        rx_i = 1'b1;
        repeat (20) @(negedge clk);
        check("fe_pulses", fe_cnt - fe0, 1);
        check("fe_valid", valid_o, 0);
        send_frame(8'h55, 1'b0, 1'b0, s);
        repeat (4) @(negedge clk);
        check("d55_data", data_o, 8'h55);
        accept();

        // short glitch on an idle line
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
        check("glitch_valid", valid_o, 0);

        // back-to-back bytes with nobody reading
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b0, 1'b0, s);
        send_frame(8'h34, 1'b0, 1'b0, s);
        repeat (4) @(negedge clk);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_data", data_o, 8'h34);
        check("ovr_valid", valid_o, 1);
        accept();

        // reset in the middle of bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_i = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        chk_en = 1'b0;
        rst_i  = 1'b1;
        #1;
        check("mid_rst_data", data_o, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_flags", {frame_err_o, overrun_o, parity_err_o}, 0);
        model_clear();
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        repeat (30) @(negedge clk);
        chk_en = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        send_frame(8'h7E, 1'b0, 1'b0, s);
        repeat (4) @(negedge clk);
        check("d7e_data", data_o, 8'h7E);
        check("d7e_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
        accept();

`ifdef UART_RX_PARITY_EN
        pe0 = pe_cnt;
        send_frame(8'h01, 1'b0, 1'b1, s);
        repeat (4) @(negedge clk);
        check("par_bad_pulses", pe_cnt - pe0, 1);
        check("par_bad_valid", valid_o, 0);
        send_frame(8'h01, 1'b0, 1'b0, s);
        repeat (4) @(negedge clk);
        check("par_ok_data", data_o, 8'h01);
        check("par_ok_valid", valid_o, 1);
        accept();
`endif

        // random frames, stop/parity errors, reader behaviour and glitches
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom_range(0, 255));
            bs = ($urandom_range(0, 5) == 0);
            bp = PAR && !bs && ($urandom_range(0, 4) == 0);
            ready_i = 1'($urandom_range(0, 1));
            send_frame(d, bs, bp, s);
            rx_i = 1'b1;
            if (bs) repeat (CPB) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                rx_i = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                rx_i = 1'b1;
                repeat (2 * CPB) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
            end
        end
        ready_i = 1'b0;
        repeat (20) @(negedge clk);
        check("events_drained", ev_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial receive stage for the chip8 top level, between the `rs232_rx_i` pin and the loader/command logic that consumes host bytes. It synchronises the asynchronous line, detects 8N1 frames by counting clock cycles, and presents each good byte through a one-entry valid/ready holding register. Framing, overrun and (optionally) parity errors are flagged with single-cycle pulses.

## Interface
- `CLK_HZ`, 12000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT` = `CLK_HZ/BAUD` (integer division). `HALF` = `CLKS_PER_BIT/2`. Requires `CLKS_PER_BIT` ≥ 4.

Ports:
- `clk_i` in 1: system clock. One clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `rx_i` in 1: raw serial line, idle high, asynchronous to `clk_i`.
- `data_o` out 8: received byte, LSB first on the line.
- `valid_o` out 1: `data_o` holds an unconsumed byte.
- `ready_i` in 1: consumer accepts the byte when `valid_o && ready_i` at a rising edge.
- `frame_err_o` out 1: one-cycle pulse; the stop bit was sampled low.
- `overrun_o` out 1: one-cycle pulse; a byte completed while the previous byte was still held.
- `parity_err_o` out 1: one-cycle pulse; parity mismatch. Tied 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- Synchroniser: `rx_i` passes through 2 flops, reset to 1. All logic uses the synchronised value `rxs`. A falling edge is detected against a third flop holding the previous `rxs`, also reset to 1.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: on a falling edge of `rxs`, clear the counter and go to START.
  - START: count to `HALF-1`, then sample. If `rxs`=1, the low was a glitch: return to IDLE with no flag. If `rxs`=0, clear the counter and the bit index, then go to DATA.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rxs` into shift bit [index]. After bit 7 is sampled, go to PARITY or STOP.
  - PARITY: sample one bit after `CLKS_PER_BIT` cycles. Even parity is required: the XOR of the 8 data bits and the parity bit must be 0. Go to STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - If `rxs`=1 and parity is OK (or parity is disabled): commit the byte.
    - If `rxs`=0: pulse `frame_err_o` and discard the byte.
    - If parity is bad: pulse `parity_err_o` and discard the byte.
    - In every case, return to IDLE. A line held low does not re-trigger until `rxs` has gone high and then fallen again.
- Commit:
  - Load `data_o` and set `valid_o`.
  - If `valid_o` was already 1 and is not being accepted in the same cycle, pulse `overrun_o`. The newest byte wins: `data_o` is overwritten.
  - If an accept and a commit happen in the same cycle, the old byte is accepted, the new byte is loaded, `valid_o` stays 1, and no overrun is flagged.
- Accept: `valid_o && ready_i` clears `valid_o` on the next edge. `data_o` keeps its value after the accept.
- Reset, including mid-frame: state goes to IDLE and all counters clear. `data_o`=0x00, `valid_o`=0, and all error outputs are 0. The synchroniser flops go to 1, so an in-progress frame is dropped.

## Timing
- All outputs are registered. Reset values are as listed under Operation.
- Latency: count from the first rising edge where `rx_i` is sampled low. `valid_o` rises at `2 + 1 + HALF + 9*CLKS_PER_BIT` cycles, plus `CLKS_PER_BIT` with the macro. A bench tolerance of ±1 cycle is allowed.
- Samples land at bit centres ±1 cycle. Cumulative error from integer `CLKS_PER_BIT` is the user's responsibility: it must be kept under 1/4 bit over 10 bits.
- Error pulses are exactly 1 cycle wide and occur on the STOP sample cycle plus 1.
- `valid_o` deasserts 1 cycle after the accepting edge.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1.
  - The PARITY state exists.
  - `parity_err_o` is live.
  - Latency grows by `CLKS_PER_BIT`.
- Not defined:
  - Frame is 8N1.
  - The PARITY state is absent.
  - `parity_err_o` is constant 0.

## Test plan
All scenarios use `CLK_HZ`=16, `BAUD`=1, giving `CLKS_PER_BIT`=16 and `HALF`=8. Drive `rx_i` with ideal 16-cycle bits.
- Send 0xA5 with `ready_i`=0 → `data_o`=0xA5 and `valid_o`=1 within 155±1 cycles of the start edge. `valid_o` holds until `ready_i`=1 for one cycle, then falls next cycle.
- Send 0x3C with the stop bit driven 0 → `frame_err_o` pulses for 1 cycle and `valid_o` stays 0. Release the line high, then send 0x55 → `data_o`=0x55.
- Pulse `rx_i` low for 4 cycles → no state leaves IDLE (after one START excursion), no flags, `valid_o`=0.
- Send 0x12 then 0x34 back-to-back with `ready_i`=0 → a single `overrun_o` pulse at the second commit, `data_o`=0x34, `valid_o`=1.
- Assert `rst_i` during bit 4 of 0xFF → all outputs are 0 immediately. Release, wait for idle, send 0x7E → `data_o`=0x7E and no error flags.
- With `UART_RX_PARITY_EN`, send 0x01 with parity bit 0 → `parity_err_o` pulses and `valid_o`=0. Send 0x01 with parity bit 1 → `data_o`=0x01 and `valid_o`=1.
